ctrl_sequencer: RTL and testbench

Hardwired control unit for the single-bus datapath. It sequences instruction fetch (T0–T2), then the execute steps (T3–T7) for load, load-immediate, store, R-type ALU, immediate ALU, mul/div, nop and halt. Every strobe the bus testbench currently drives by hand is generated here, one state per clock.

---
 rtl/cpu_ctrl_pkg.sv | 72 +++++++
 rtl/ctrl_decode.sv | 46 ++++
 rtl/ctrl_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_ctrl_pkg                                               |
// | Purpose : Shared constants and types for the hardwired control unit: |
// |           opcodes, ALU operation codes, instruction classes and FSM  |
// |           state encodings.                                           |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] c_OP_LD      = 5'b00000;
  localparam logic [4:0] c_OP_LDI     = 5'b00001;
  localparam logic [4:0] c_OP_ST      = 5'b00010;
  localparam logic [4:0] c_OP_ALUR_LO = 5'b00011;
  localparam logic [4:0] c_OP_ALUR_HI = 5'b01011;
  localparam logic [4:0] c_OP_ADDI    = 5'b01100;
  localparam logic [4:0] c_OP_ANDI    = 5'b01101;
  localparam logic [4:0] c_OP_ORI     = 5'b01110;
  localparam logic [4:0] c_OP_MUL     = 5'b10000;
  localparam logic [4:0] c_OP_DIV     = 5'b10001;
  localparam logic [4:0] c_OP_NOP     = 5'b11010;
  localparam logic [4:0] c_OP_HALT    = 5'b11011;

  // ALU operation codes
  localparam logic [4:0] c_ALU_NONE = 5'b00000;
  localparam logic [4:0] c_ALU_AND  = 5'b00011;
  localparam logic [4:0] c_ALU_OR   = 5'b00100;
  localparam logic [4:0] c_ALU_ADD  = 5'b00101;
  localparam logic [4:0] c_ALU_SUB  = 5'b00110;
  localparam logic [4:0] c_ALU_SHR  = 5'b00111;
  localparam logic [4:0] c_ALU_SHRA = 5'b01000;
  localparam logic [4:0] c_ALU_SHL  = 5'b01001;
  localparam logic [4:0] c_ALU_ROR  = 5'b01010;
  localparam logic [4:0] c_ALU_ROL  = 5'b01011;
  localparam logic [4:0] c_ALU_MUL  = 5'b10000;
  localparam logic [4:0] c_ALU_DIV  = 5'b10001;

  typedef enum logic [3:0] {
    CL_LD     = 4'd0,
    CL_LDI    = 4'd1,
    CL_ST     = 4'd2,
    CL_ALUR   = 4'd3,
    CL_ALUI   = 4'd4,
    CL_MULDIV = 4'd5,
    CL_NOP    = 4'd6,
    CL_HALT   = 4'd7,
    CL_ILL    = 4'd8
  } instr_class_e;

  typedef enum logic [4:0] {
    S_RST   = 5'd0,
    S_T0    = 5'd1,
    S_T1    = 5'd2,
    S_T2    = 5'd3,
    S_T3    = 5'd4,
    S_T4    = 5'd5,
    S_T5    = 5'd6,
    S_T6    = 5'd7,
    S_T7    = 5'd8,
    S_PAUSE = 5'd9,
    S_HALT  = 5'd10
  } state_e;

  // Classes whose operand address comes from Rb + constant (BAout path)
  function automatic logic is_mem_class(input instr_class_e cls);
    return (cls == CL_LD) || (cls == CL_LDI) || (cls == CL_ST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ctrl_decode                                                |
// | Purpose : Combinational opcode decoder: instruction class and the    |
// |           ALU operation to present during execute.                   |
// | Ports   : i_opcode [OPW] in  - IR opcode field                       |
// |           o_cls         out - instruction class                      |
// |           o_alu_op [5]  out - ALU operation code                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] i_opcode,
  output instr_class_e   o_cls,
  output logic [4:0]     o_alu_op
);

  always_comb begin
    o_cls    = CL_ILL;
    o_alu_op = c_ALU_NONE;
    if ((i_opcode >= c_OP_ALUR_LO) && (i_opcode <= c_OP_ALUR_HI)) begin
      // R-type opcodes double as their own ALU operation code
      o_cls    = CL_ALUR;
      o_alu_op = i_opcode;
    end else begin
      case (i_opcode)
        c_OP_LD:   begin o_cls = CL_LD;     o_alu_op = c_ALU_ADD; end
        c_OP_LDI:  begin o_cls = CL_LDI;    o_alu_op = c_ALU_ADD; end
        c_OP_ST:   begin o_cls = CL_ST;     o_alu_op = c_ALU_ADD; end
        c_OP_ADDI: begin o_cls = CL_ALUI;   o_alu_op = c_ALU_ADD; end
        c_OP_ANDI: begin o_cls = CL_ALUI;   o_alu_op = c_ALU_AND; end
        c_OP_ORI:  begin o_cls = CL_ALUI;   o_alu_op = c_ALU_OR;  end
        c_OP_MUL:  begin o_cls = CL_MULDIV; o_alu_op = c_ALU_MUL; end
        c_OP_DIV:  begin o_cls = CL_MULDIV; o_alu_op = c_ALU_DIV; end
        c_OP_NOP:  o_cls = CL_NOP;
        c_OP_HALT: o_cls = CL_HALT;
        default:   o_cls = CL_ILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ctrl_sequencer                                             |
// | Purpose : Hardwired control unit for the single-bus datapath. Runs   |
// |           fetch (T0-T2) and execute (T3-T7), one state per clock.    |
// | Ports   : clock, clear (sync active-low) ; IR[32] ; mem_ready ; stop |
// |           PC/MAR/MDR/IR/Y/Z/HI/LO strobes, register-select strobes,  |
// |           operation[5], run, illegal, state[5] (debug)               |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ctrl_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        read,
  output logic        write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic [4:0]  operation,
  output logic        run,
  output logic        illegal,
  output logic [4:0]  state
);

  state_e       r_state;
  state_e       w_next;
  state_e       w_inst_end;
  instr_class_e w_cls;
  logic [4:0]   w_alu_op;
  logic         w_unused_ir;

  // Register fields are consumed by the datapath's select logic, not here
  assign w_unused_ir = ^IR[31-OPW:0];

  ctrl_decode #(.OPW(OPW)) u_decode (
    .i_opcode (IR[31 -: OPW]),
    .o_cls    (w_cls),
    .o_alu_op (w_alu_op)
  );

  assign w_inst_end = stop ? S_PAUSE : S_T0;
  assign state      = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = stop ? S_PAUSE : S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = mem_ready ? S_T2 : S_T1;
      S_T2:    w_next = S_T3;
      S_T3: begin
        if (w_cls == CL_HALT)                            w_next = S_HALT;
        else if ((w_cls == CL_NOP) || (w_cls == CL_ILL)) w_next = w_inst_end;
        else                                             w_next = S_T4;
      end
      S_T4:    w_next = S_T5;
      S_T5: begin
        if ((w_cls == CL_LD) || (w_cls == CL_ST) || (w_cls == CL_MULDIV)) w_next = S_T6;
        else                                                               w_next = w_inst_end;
      end
      S_T6: begin
        if (w_cls == CL_MULDIV)  w_next = w_inst_end;
        else if (w_cls == CL_ST) w_next = S_T7;
        else                     w_next = mem_ready ? S_T7 : S_T6;
      end
      S_T7: begin
        if ((w_cls == CL_ST) && !mem_ready) w_next = S_T7;
        else                                w_next = w_inst_end;
      end
      S_PAUSE: w_next = stop ? S_PAUSE : S_T0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) r_state <= S_RST;
    else        r_state <= w_next;
  end

  // Strobes follow the registered state. The class comes from IR, which the
  // datapath loads at the end of T2, so it is only consulted from T3 onward.
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, read, write, IRin, Yin,
     Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin, Gra, Grb, Grc, Rin,
     Rout, BAout, Cout, illegal} = '0;
    operation = c_ALU_NONE;
    run       = 1'b1;
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      S_T1: begin ZLOout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (w_cls)
          CL_NOP, CL_HALT: ;
          CL_ILL:  illegal = 1'b1;
          default: begin
            Grb   = 1'b1;
            Yin   = 1'b1;
            BAout = is_mem_class(w_cls);
            Rout  = !is_mem_class(w_cls);
          end
        endcase
      end
      S_T4: begin
        operation = w_alu_op;
        Zlowin    = 1'b1;
        if ((w_cls == CL_ALUR) || (w_cls == CL_MULDIV)) begin
          Grc     = 1'b1;
          Rout    = 1'b1;
          Zhighin = (w_cls == CL_MULDIV);
        end else begin
          Cout = 1'b1;
        end
      end
      S_T5: begin
        operation = w_alu_op;
        ZLOout    = 1'b1;
        if ((w_cls == CL_LD) || (w_cls == CL_ST)) MARin = 1'b1;
        else if (w_cls == CL_MULDIV)              LOin  = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      S_T6: begin
        operation = w_alu_op;
        if (w_cls == CL_MULDIV)  begin ZHIout = 1'b1; HIin = 1'b1; end
        else if (w_cls == CL_ST) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else                     begin read = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        operation = w_alu_op;
        if (w_cls == CL_ST) write = 1'b1;
        else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      default: run = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ctrl_sequencer                                          |
// | Purpose : Self-checking bench for ctrl_sequencer. Each instruction   |
// |           is expanded into a per-cycle list of expected strobes from |
// |           the instruction-class tables, then replayed cycle by cycle.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        clear, mem_ready, stop;
  logic [31:0] IR;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, read, write, IRin, Yin;
  logic Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin, Gra, Grb, Grc, Rin;
  logic Rout, BAout, Cout, run, illegal;
  logic [4:0] operation, state;

  always #5 clock = ~clock;

  ctrl_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .read(read), .write(write), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .BAout(BAout), .Cout(Cout), .operation(operation),
    .run(run), .illegal(illegal), .state(state)
  );

  logic [24:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, read, write, IRin, Yin,
                Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin, Gra, Grb, Grc, Rin,
                Rout, BAout, Cout, run, illegal};

  localparam logic [24:0] K_PCOUT = 25'(1) << 24, K_PCIN   = 25'(1) << 23;
  localparam logic [24:0] K_INCPC = 25'(1) << 22, K_MARIN  = 25'(1) << 21;
  localparam logic [24:0] K_MDRIN = 25'(1) << 20, K_MDROUT = 25'(1) << 19;
  localparam logic [24:0] K_READ  = 25'(1) << 18, K_WRITE  = 25'(1) << 17;
  localparam logic [24:0] K_IRIN  = 25'(1) << 16, K_YIN    = 25'(1) << 15;
  localparam logic [24:0] K_ZLOW  = 25'(1) << 14, K_ZHIGH  = 25'(1) << 13;
  localparam logic [24:0] K_ZLOO  = 25'(1) << 12, K_ZHIO   = 25'(1) << 11;
  localparam logic [24:0] K_HIIN  = 25'(1) << 10, K_LOIN   = 25'(1) << 9;
  localparam logic [24:0] K_GRA   = 25'(1) << 8,  K_GRB    = 25'(1) << 7;
  localparam logic [24:0] K_GRC   = 25'(1) << 6,  K_RIN    = 25'(1) << 5;
  localparam logic [24:0] K_ROUT  = 25'(1) << 4,  K_BAOUT  = 25'(1) << 3;
  localparam logic [24:0] K_COUT  = 25'(1) << 2,  K_RUN    = 25'(1) << 1;
  localparam logic [24:0] K_ILL   = 25'(1);

  localparam int LD = 0, LDI = 1, ST = 2, ALUR = 3, ALUI = 4, MD = 5, NOP = 6, HLT = 7, ILL = 8;

  typedef struct {
    logic [24:0] v;
    logic [4:0]  op;
    bit          mr;
    bit          stp;
    bit          clr;
    logic [31:0] ir;
  } step_t;

  step_t       q[$];
  logic [31:0] cur_ir = '0;
  string       tag = "reset";
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(logic [24:0] v, logic [4:0] op, bit mr, bit stp);
    step_t e;
    e.v = v; e.op = op; e.mr = mr; e.stp = stp; e.clr = 1'b1; e.ir = cur_ir;
    q.push_back(e);
  endfunction

  function automatic void pushz(bit stp, bit clr);
    step_t e;
    e.v = '0; e.op = 5'd0; e.mr = rb(); e.stp = stp; e.clr = clr; e.ir = cur_ir;
    q.push_back(e);
  endfunction

  // Expected cycle list for one instruction: fetch, class-specific execute,
  // then optional PAUSE cycles if stop is raised at the instruction end.
  function automatic void build(logic [31:0] ir, int w1, int wm, bit stop_end, int plen);
    logic [4:0] opc;
    logic [4:0] aop;
    int         kind;
    step_t      e;
    cur_ir = ir;
    opc    = ir[31:27];
    if (opc == 0)                     kind = LD;
    else if (opc == 1)                kind = LDI;
    else if (opc == 2)                kind = ST;
    else if (opc >= 3 && opc <= 11)   kind = ALUR;
    else if (opc >= 12 && opc <= 14)  kind = ALUI;
    else if (opc == 16 || opc == 17)  kind = MD;
    else if (opc == 26)               kind = NOP;
    else if (opc == 27)               kind = HLT;
    else                              kind = ILL;
    if (kind == ALUR || kind == MD) aop = opc;
    else if (opc == 13)             aop = 5'd3;
    else if (opc == 14)             aop = 5'd4;
    else                            aop = 5'd5;

    push(K_PCOUT | K_MARIN | K_INCPC | K_ZLOW | K_RUN, 0, rb(), rb());
    for (int i = 0; i < w1; i++) push(K_ZLOO | K_PCIN | K_READ | K_MDRIN | K_RUN, 0, 1'b0, rb());
    push(K_ZLOO | K_PCIN | K_READ | K_MDRIN | K_RUN, 0, 1'b1, rb());
    push(K_MDROUT | K_IRIN | K_RUN, 0, rb(), rb());

    case (kind)
      ILL:         push(K_RUN | K_ILL, 0, rb(), rb());
      NOP, HLT:    push(K_RUN, 0, rb(), rb());
      LD, LDI, ST: push(K_GRB | K_YIN | K_BAOUT | K_RUN, 0, rb(), rb());
      default:     push(K_GRB | K_YIN | K_ROUT | K_RUN, 0, rb(), rb());
    endcase
    if (kind == HLT) return;

    case (kind)
      ALUR: begin
        push(K_GRC | K_ROUT | K_ZLOW | K_RUN, aop, rb(), rb());
        push(K_ZLOO | K_GRA | K_RIN | K_RUN, aop, rb(), rb());
      end
      ALUI, LDI: begin
        push(K_COUT | K_ZLOW | K_RUN, aop, rb(), rb());
        push(K_ZLOO | K_GRA | K_RIN | K_RUN, aop, rb(), rb());
      end
      MD: begin
        push(K_GRC | K_ROUT | K_ZLOW | K_ZHIGH | K_RUN, aop, rb(), rb());
        push(K_ZLOO | K_LOIN | K_RUN, aop, rb(), rb());
        push(K_ZHIO | K_HIIN | K_RUN, aop, rb(), rb());
      end
      LD: begin
        push(K_COUT | K_ZLOW | K_RUN, aop, rb(), rb());
        push(K_ZLOO | K_MARIN | K_RUN, aop, rb(), rb());
        for (int i = 0; i < wm; i++) push(K_READ | K_MDRIN | K_RUN, aop, 1'b0, rb());
        push(K_READ | K_MDRIN | K_RUN, aop, 1'b1, rb());
        push(K_MDROUT | K_GRA | K_RIN | K_RUN, aop, rb(), rb());
      end
      ST: begin
        push(K_COUT | K_ZLOW | K_RUN, aop, rb(), rb());
        push(K_ZLOO | K_MARIN | K_RUN, aop, rb(), rb());
        push(K_GRA | K_ROUT | K_MDRIN | K_RUN, aop, rb(), rb());
        for (int i = 0; i < wm; i++) push(K_WRITE | K_RUN, aop, 1'b0, rb());
        push(K_WRITE | K_RUN, aop, 1'b1, rb());
      end
      default: ;
    endcase

    e = q[$];
    void'(q.pop_back());
    e.stp = stop_end;
    q.push_back(e);
    if (stop_end) begin
      for (int i = 0; i < plen - 1; i++) pushz(1'b1, 1'b1);
      pushz(1'b0, 1'b1);
    end
  endfunction

  // Drop clear during entry idx; the next cycle must be RST, then T0.
  function automatic void abort_at(int idx);
    step_t e;
    while (q.size() > idx + 1) void'(q.pop_back());
    e = q[$];
    void'(q.pop_back());
    e.clr = 1'b0;
    q.push_back(e);
    pushz(1'b0, 1'b1);
  endfunction

  task automatic apply(input step_t e);
    @(negedge clock);
    vectors++;
    assert (obs === e.v) else begin
      miscompares++;
      $error("FAIL %s strobes: got %b want %b", tag, obs, e.v);
    end
    vectors++;
    assert (operation === e.op) else begin
      miscompares++;
      $error("FAIL %s operation: got %b want %b", tag, operation, e.op);
    end
    clear     = e.clr;
    mem_ready = e.mr;
    stop      = e.stp;
    IR        = e.ir;
  endtask

  task automatic drain();
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      apply(e);
    end
  endtask

  initial begin
    logic [4:0] opc;
    clear = 1'b0; mem_ready = 1'b0; stop = 1'b0; IR = '0;

    tag = "reset";
    pushz(1'b0, 1'b0);
    pushz(1'b0, 1'b1);
    drain();

    tag = "and_r";      build(32'h18228000, 0, 0, 1'b0, 1); drain();
    tag = "and_r_wait"; build(32'h18228000, 3, 0, 1'b0, 1); drain();
    tag = "ld_wait";    build({5'b00000, 27'($urandom)}, 0, 2, 1'b0, 1); drain();
    tag = "mul";        build({5'b10000, 27'($urandom)}, 0, 0, 1'b0, 1); drain();
    tag = "div";        build({5'b10001, 27'($urandom)}, 1, 0, 1'b0, 1); drain();
    tag = "st_wait";    build({5'b00010, 27'($urandom)}, 0, 2, 1'b0, 1); drain();
    tag = "ldi";        build({5'b00001, 27'($urandom)}, 0, 0, 1'b0, 1); drain();
    tag = "andi";       build({5'b01101, 27'($urandom)}, 0, 0, 1'b0, 1); drain();
    tag = "ori";        build({5'b01110, 27'($urandom)}, 0, 0, 1'b0, 1); drain();
    tag = "addi";       build({5'b01100, 27'($urandom)}, 0, 0, 1'b0, 1); drain();
    tag = "nop";        build({5'b11010, 27'($urandom)}, 0, 0, 1'b0, 1); drain();
    tag = "illegal";    build({5'b11111, 27'($urandom)}, 0, 0, 1'b0, 1); drain();
    tag = "stop_pause"; build({5'b00101, 27'($urandom)}, 0, 0, 1'b1, 3); drain();
    tag = "abort_t4";   build({5'b00101, 27'($urandom)}, 0, 0, 1'b0, 1); abort_at(4); drain();

    tag = "halt";
    build({5'b11011, 27'($urandom)}, 0, 0, 1'b0, 1);
    for (int i = 0; i < 20; i++) pushz(rb(), 1'b1);
    pushz(1'b0, 1'b0);   // last HALT cycle: drop clear
    pushz(1'b1, 1'b1);   // RST with stop held -> PAUSE
    pushz(1'b1, 1'b1);
    pushz(1'b0, 1'b1);   // PAUSE released -> T0
    drain();
    tag = "after_halt"; build(32'h18228000, 0, 0, 1'b0, 1); drain();

    tag = "random";
    for (int n = 0; n < 60; n++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd27) opc = 5'd26;
      build({opc, 27'($urandom)}, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(1, 3)));
      if ($urandom_range(0, 7) == 0) abort_at(int'($urandom_range(0, q.size() - 1)));
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
